cache_block_buffer: RTL



---
 rtl/cache_block_buffer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_block_buffer.sv
// rtl/cache_block_buffer.sv - block-transfer buffer between a cache memory-side port and the next memory level
//
// Purpose:
//   Carries one whole-block request at a time. A writeback collects N words
//   from the cache and then streams them downstream. A fill fetches N words
//   from downstream and then offers them to the cache one word per pop.
//   Words move in ascending offset order in both directions.
//
// Optional feature (compile-time macro):
//   BLOCK_BUFFER_EARLY_READ_EN - fill words are offered to the cache as soon
//   as each one is stored, instead of after the whole block has arrived.
//
// Ports:
//   clock_i, resetn_i       clock, synchronous active-low reset
//   cache_req_i/rw_i/add_i  block request from cache (rw: 1 writeback, 0 fill)
//   cache_write_i/data_i    cache pushes a writeback word
//   cache_read_i            cache pops a fill word
//   ready_req_o             buffer idle and able to take a request
//   ready_write_o           buffer able to take a writeback word
//   ready_read_o            fill word available on cache_data_o
//   cache_data_o            current fill word (0 when not ready)
//   mem_req_o/rw_o/add_o    downstream request, held until mem_ack_i
//   mem_ack_i               downstream accepts the request
//   mem_wvalid_o/data_o     writeback word to downstream (data 0 when not valid)
//   mem_wready_i            downstream consumes the writeback word
//   mem_rvalid_i/data_i     fill word from downstream

module cache_block_buffer #(
    parameter int BW_WORD_ADDR = 24,
    parameter int BW_BLOCK     = 2
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    cache_req_i,
    input  logic                    cache_rw_i,
    input  logic [BW_WORD_ADDR-1:0] cache_add_i,
    input  logic                    cache_write_i,
    input  logic [31:0]             cache_data_i,
    input  logic                    cache_read_i,
    output logic                    ready_req_o,
    output logic                    ready_write_o,
    output logic                    ready_read_o,
    output logic [31:0]             cache_data_o,
    output logic                    mem_req_o,
    output logic                    mem_rw_o,
    output logic [BW_WORD_ADDR-1:0] mem_add_o,
    input  logic                    mem_ack_i,
    output logic                    mem_wvalid_o,
    output logic [31:0]             mem_data_o,
    input  logic                    mem_wready_i,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_data_i
);

    localparam int N = 1 << BW_BLOCK;
    // Counters are one bit wider than the word offset so they can hold N.
    localparam logic [BW_BLOCK:0]     CNT_N    = (BW_BLOCK + 1)'(N);
    localparam logic [BW_BLOCK:0]     CNT_LAST = (BW_BLOCK + 1)'(N - 1);
    localparam logic [BW_BLOCK:0]     CNT_ONE  = (BW_BLOCK + 1)'(1);
    localparam logic [BW_WORD_ADDR-1:0] ADDR_MASK = ~BW_WORD_ADDR'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFILL,
        S_WREQ,
        S_WSEND,
        S_RREQ,
        S_RFILL,
        S_RDRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [BW_WORD_ADDR-1:0] add_q, add_d;
    logic [BW_BLOCK:0]       wr_cnt_q, wr_cnt_d;
    logic [BW_BLOCK:0]       rd_idx_q, rd_idx_d;
    logic [31:0]             blk_q [N];
    logic [31:0]             blk_d [N];

    logic                    accept;
    logic                    cache_store;
    logic                    mem_store;
    logic                    pop_fire;
    logic                    send_fire;

    // Handshake strobes; each qualifies an input with an output that is
    // itself decoded from registered state, so no comb loop exists.
    assign accept      = (state_q == S_IDLE) && cache_req_i;
    assign cache_store = ready_write_o && cache_write_i;
    assign mem_store   = (state_q == S_RFILL) && mem_rvalid_i && (wr_cnt_q < CNT_N);
    assign pop_fire    = ready_read_o && cache_read_i;
    assign send_fire   = mem_wvalid_o && mem_wready_i;

    // State register and datapath registers.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            add_q    <= '0;
            wr_cnt_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            add_q    <= add_d;
            wr_cnt_q <= wr_cnt_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Block storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        blk_q <= blk_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cache_req_i) begin
                    state_d = cache_rw_i ? S_WFILL : S_RREQ;
                end
            end
            S_WFILL: begin
                if (cache_store && (wr_cnt_q == CNT_LAST)) begin
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                if (mem_ack_i) begin
                    state_d = S_WSEND;
                end
            end
            S_WSEND: begin
                if (send_fire && (rd_idx_q == CNT_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            S_RREQ: begin
                if (mem_ack_i) begin
                    state_d = S_RFILL;
                end
            end
            S_RFILL: begin
`ifdef BLOCK_BUFFER_EARLY_READ_EN
                // Fill and drain overlap; done once the last word is popped.
                if (pop_fire && (rd_idx_q == CNT_LAST)) begin
                    state_d = S_IDLE;
                end
`else
                if (mem_store && (wr_cnt_q == CNT_LAST)) begin
                    state_d = S_RDRAIN;
                end
`endif
            end
            S_RDRAIN: begin
                if (pop_fire && (rd_idx_q == CNT_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: address latch, counters and block storage.
    always_comb begin
        add_d    = add_q;
        wr_cnt_d = wr_cnt_q;
        rd_idx_d = rd_idx_q;
        blk_d    = blk_q;
        if (accept) begin
            add_d    = cache_add_i & ADDR_MASK;
            wr_cnt_d = '0;
            rd_idx_d = '0;
        end
        if (cache_store) begin
            blk_d[wr_cnt_q[BW_BLOCK-1:0]] = cache_data_i;
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end
        if (mem_store) begin
            blk_d[wr_cnt_q[BW_BLOCK-1:0]] = mem_data_i;
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end
        if (pop_fire || send_fire) begin
            rd_idx_d = rd_idx_q + CNT_ONE;
        end
    end

    // Output decode, purely from registered state and counters.
    always_comb begin
        ready_req_o   = 1'b0;
        ready_write_o = 1'b0;
        ready_read_o  = 1'b0;
        cache_data_o  = '0;
        mem_req_o     = 1'b0;
        mem_rw_o      = 1'b0;
        mem_add_o     = '0;
        mem_wvalid_o  = 1'b0;
        mem_data_o    = '0;
        unique case (state_q)
            S_IDLE: begin
                ready_req_o = 1'b1;
            end
            S_WFILL: begin
                ready_write_o = (wr_cnt_q < CNT_N);
            end
            S_WREQ: begin
                mem_req_o = 1'b1;
                mem_rw_o  = 1'b1;
                mem_add_o = add_q;
            end
            S_WSEND: begin
                mem_wvalid_o = 1'b1;
                mem_data_o   = blk_q[rd_idx_q[BW_BLOCK-1:0]];
            end
            S_RREQ: begin
                mem_req_o = 1'b1;
                mem_add_o = add_q;
            end
            S_RFILL: begin
`ifdef BLOCK_BUFFER_EARLY_READ_EN
                // A word is visible only once it has been registered.
                ready_read_o = (rd_idx_q < wr_cnt_q);
                if (ready_read_o) begin
                    cache_data_o = blk_q[rd_idx_q[BW_BLOCK-1:0]];
                end
`endif
            end
            S_RDRAIN: begin
                ready_read_o = (rd_idx_q < CNT_N);
                if (ready_read_o) begin
                    cache_data_o = blk_q[rd_idx_q[BW_BLOCK-1:0]];
                end
            end
            default: begin
            end
        endcase
    end

endmodule
